// File: rtl/aes128_pkg.sv
// Shared AES-128 constants, round-controller states and the
// linear round helpers (ShiftRows, MixColumns) used by the cipher datapath.
package aes128_pkg;

    localparam int AES128_NUM_ROUNDS = 10;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

    function automatic logic [7:0] mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return mul2(b) ^ b;
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] c);
        logic [7:0] b0, b1, b2, b3;
        b0 = c[31:24];
        b1 = c[23:16];
        b2 = c[15:8];
        b3 = c[7:0];
        return {mul2(b0) ^ mul3(b1) ^ b2 ^ b3,
                b0 ^ mul2(b1) ^ mul3(b2) ^ b3,
                b0 ^ b1 ^ mul2(b2) ^ mul3(b3),
                mul3(b0) ^ b1 ^ b2 ^ mul2(b3)};
    endfunction

    // Byte 4c+r sits at row r, column c; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes128_sbox_enc.sv
// Forward AES S-box: inversion through the GF(2^4) subfield norm,
// followed by the AES affine transform.
module aes128_sbox_enc
    import aes128_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = mul2(x);
        end
        return p;
    endfunction

    logic [7:0] x2, x4, x8, x16;
    logic [7:0] nrm, n2, n4, n8, ninv;
    logic [7:0] inv;

    // x^-1 = x^16 * (x^17)^-1; x^17 lies in GF(16), so its inverse is n^14.
    always_comb begin
        x2   = gf_mul(in_byte, in_byte);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        nrm  = gf_mul(x16, in_byte);
        n2   = gf_mul(nrm, nrm);
        n4   = gf_mul(n2, n2);
        n8   = gf_mul(n4, n4);
        ninv = gf_mul(gf_mul(n8, n4), n2);
        inv  = gf_mul(x16, ninv);
    end

    assign out_byte = inv
                    ^ {inv[6:0], inv[7]}
                    ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]}
                    ^ 8'h63;

endmodule

// File: rtl/aes128_cipher_round.sv
// Iterative AES-128 encryption core: one round per cycle, with the
// external round-key generator stepped through round_num/cipher_en.
module aes128_cipher_round
    import aes128_pkg::*;
(
    input  logic         clk_sys,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] cipher_key,
    output logic [3:0]   round_num,
    output logic         cipher_en,
    input  logic [127:0] round_key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam logic [3:0] LAST_RND = 4'(AES128_NUM_ROUNDS);

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;

    logic [127:0] sb, sr, mc;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes128_sbox_enc u_sbox (
            .in_byte  (state_q[127-8*i -: 8]),
            .out_byte (sb[127-8*i -: 8])
        );
    end

    always_comb begin
        sr = shift_rows(sb);
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            mc[127-32*c -: 32] = mixcol(sr[127-32*c -: 32]);
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        rnd_d     = rnd_q;
        state_d   = state_q;
        in_ready  = 1'b0;
        cipher_en = 1'b0;
        round_num = 4'd0;
        unique case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d   = in_data ^ cipher_key;
                    cipher_en = 1'b1;
                    rnd_d     = 4'd1;
                    fsm_d     = ROUND;
                end
            end
            ROUND: begin
                round_num = rnd_q;
                if (rnd_q == LAST_RND) begin
                    state_d = sr ^ round_key_in;
                    rnd_d   = 4'd0;
                    fsm_d   = DONE;
                end else begin
                    state_d   = mc ^ round_key_in;
                    cipher_en = 1'b1;
                    rnd_d     = rnd_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            rnd_q   <= 4'd0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
        end
    end

    assign out_valid = (fsm_q == DONE);
    assign out_data  = state_q;

endmodule

// File: tb/tb_aes128_cipher_round.sv
// Directed FIPS-197 vectors against aes128_cipher_round, with a
// behavioural round-key generator closing the round_num/cipher_en loop.
module tb_aes128_cipher_round;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK1_B = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk_sys = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] cipher_key;
    logic [3:0]   round_num;
    logic         cipher_en;
    logic [127:0] round_key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int n_pass  = 0;
    int n_total = 0;

    aes128_cipher_round dut (
        .clk_sys      (clk_sys),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .cipher_key   (cipher_key),
        .round_num    (round_num),
        .cipher_en    (cipher_en),
        .round_key_in (round_key_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        logic [7:0] c = 8'h63;
        for (int i = 1; i < 256; i++) begin
            if (m_mul(x, 8'(i)) == 8'h01) inv = 8'(i);
        end
        for (int i = 0; i < 8; i++) begin
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
                 ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        end
        return s;
    endfunction

    function automatic logic [127:0] m_next_key(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc = 8'h01;
        for (int i = 1; i < int'(r); i++) begin
            rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
        end
        {w0, w1, w2, w3} = k;
        t  = {w3[23:0], w3[31:24]};
        t  = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
        t  = t ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Behavioural key generator: registered next round key on cipher_en.
    logic [127:0] rk_q = '0;
    always @(posedge clk_sys) begin
        if (cipher_en) begin
            rk_q <= m_next_key((round_num == 4'd0) ? cipher_key : rk_q,
                               4'(round_num + 4'd1));
        end
    end
    assign round_key_in = rk_q;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_block(input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] ct, input string tag,
                            input bit inject, input bit chk_rk1, input int stall);
        logic [43:0]  rn_seq;
        logic [127:0] rk1;
        int           en_cnt;
        int           early;
        int           bad;
        in_data    = pt;
        cipher_key = key;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        #1;
        rn_seq = {40'h0, round_num};
        en_cnt = int'(cipher_en);
        early  = 0;
        rk1    = '0;
        tick();
        in_valid   = 1'b0;
        in_data    = '0;
        cipher_key = ~key;
        for (int k = 1; k <= 10; k++) begin
            #1;
            rn_seq = {rn_seq[39:0], round_num};
            en_cnt += int'(cipher_en);
            if (out_valid) early++;
            if (k == 1) rk1 = round_key_in;
            if (inject && k == 4) begin
                in_valid = 1'b1;
                in_data  = ~pt;
            end
            tick();
            in_valid = 1'b0;
            in_data  = '0;
        end
        #1;
        en_cnt += int'(cipher_en);
        chk({tag, ".round_num_seq"}, 128'(rn_seq), 128'h0123456789A);
        chk({tag, ".cipher_en_cycles"}, 128'(en_cnt), 128'd10);
        chk({tag, ".out_valid_early"}, 128'(early), 128'd0);
        chk({tag, ".out_valid_lat11"}, 128'(out_valid), 128'd1);
        chk({tag, ".out_data"}, out_data, ct);
        chk({tag, ".in_ready_done"}, 128'(in_ready), 128'd0);
        if (chk_rk1) chk({tag, ".round_key_r1"}, rk1, RK1_B);
        bad = 0;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (out_data !== ct || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        if (stall > 0) chk({tag, ".stall_stable"}, 128'(bad), 128'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".idle_in_ready"}, 128'(in_ready), 128'd1);
        chk({tag, ".idle_out_valid"}, 128'(out_valid), 128'd0);
    endtask

    initial begin
        logic [127:0] outs [2];
        int           acc  [2];
        int           na;
        int           no;
        bit           hs_in;
        bit           hs_out;
        logic [127:0] od;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        cipher_key = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        chk("reset.in_ready", 128'(in_ready), 128'd1);
        chk("reset.out_valid", 128'(out_valid), 128'd0);
        chk("reset.out_data", out_data, 128'd0);
        chk("reset.round_num", 128'(round_num), 128'd0);
        chk("reset.cipher_en", 128'(cipher_en), 128'd0);
        rst = 1'b0;
        tick();

        do_block(PT_B, KEY_B, CT_B, "appB", 1'b0, 1'b1, 5);
        tick();
        do_block(PT_B, KEY_B, CT_B, "appB_inject", 1'b1, 1'b0, 0);
        tick();

        in_data    = PT_C;
        cipher_key = KEY_C;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("midrst.round6", 128'(round_num), 128'd6);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst.in_ready", 128'(in_ready), 128'd1);
        chk("midrst.out_valid", 128'(out_valid), 128'd0);
        chk("midrst.out_data", out_data, 128'd0);
        chk("midrst.round_num", 128'(round_num), 128'd0);
        chk("midrst.cipher_en", 128'(cipher_en), 128'd0);
        tick();
        rst = 1'b0;
        tick();
        do_block(PT_C, KEY_C, CT_C, "appC1", 1'b0, 1'b0, 0);
        tick();

        na         = 0;
        no         = 0;
        acc[0]     = 0;
        acc[1]     = 0;
        outs[0]    = '0;
        outs[1]    = '0;
        in_data    = PT_C;
        cipher_key = KEY_C;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        for (int t = 0; t < 60 && no < 2; t++) begin
            #1;
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            od     = out_data;
            tick();
            if (hs_in) begin
                acc[na] = t;
                na++;
                if (na == 1) begin
                    in_data    = PT_B;
                    cipher_key = KEY_B;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (hs_out) begin
                outs[no] = od;
                no++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b.outputs_seen", 128'(no), 128'd2);
        chk("b2b.accept_gap", 128'(acc[1] - acc[0]), 128'd12);
        chk("b2b.ct0", outs[0], CT_C);
        chk("b2b.ct1", outs[1], CT_B);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
